// File: rtl/cpu_bus_if.sv
// Memory bus between the accumulator CPU and its ROM/RAM, exported for observation.
interface cpu_bus_if;
  // Strobe semantics: mem_read/mem_write are level strobes held for one full cycle;
  // a read returns mem2cpu combinationally, a write commits on the closing clock edge.
  logic [7:0] adrs;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] dout;
  logic [7:0] mem2cpu;
  logic [7:0] rom_dout;

  modport master (output adrs, mem_read, mem_write, dout, mem2cpu, rom_dout);
  modport slave  (input  adrs, mem_read, mem_write, dout, mem2cpu, rom_dout);
endinterface

// File: rtl/cpu_system.sv
// 8-bit accumulator CPU with 32-byte program ROM and 4-byte RAM; a step counter
// sequences fetch/operand/execute through one shared ALU.
module cpu_system (
  input  logic       clk,
  input  logic       rst,
  cpu_bus_if.master  bus,
  output logic [7:0] pr,
  output logic [7:0] mar,
  output logic [7:0] ir,
  output logic [7:0] gr,
  output logic [2:0] sc,
  output logic [7:0] ram20,
  output logic [7:0] ram21,
  output logic [7:0] ram22,
  output logic [7:0] ram23
);

  typedef enum logic [2:0] {
    SC0 = 3'd0,
    SC1 = 3'd1,
    SC2 = 3'd2,
    SC3 = 3'd3,
    SC4 = 3'd4
  } step_t;

  typedef enum logic [1:0] {
    ALU_A   = 2'b00,
    ALU_INC = 2'b01,
    ALU_ADD = 2'b10,
    ALU_B   = 2'b11
  } alu_op_t;

  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_ST  = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_JMP = 8'h04;
  localparam logic [7:0] OP_HLT = 8'hFF;

  step_t      step, step_nxt;
  logic       rom_cs, ram_cs;
  logic [7:0] rom_data, ram_dout;
  logic [7:0] ram [4];

  logic       a_sel;
  alu_op_t    alu_sel;
  logic [7:0] alu_a, alu_y;
  logic       pr_load, mar_load, mar_from_din, ir_load, gr_load;
  logic       sc_clear, sc_hold;

  // ---------------- memory ----------------
  assign bus.adrs = mar;
  assign bus.dout = gr;
  assign rom_cs   = (bus.adrs[7:5] == 3'b000);
  assign ram_cs   = (bus.adrs[7:2] == 6'b001000);

  always_comb begin
    rom_data = 8'h00;
    case (bus.adrs[4:0])
      5'h00: rom_data = 8'h01;
      5'h01: rom_data = 8'h1E;
      5'h02: rom_data = 8'h03;
      5'h03: rom_data = 8'h1F;
      5'h04: rom_data = 8'h02;
      5'h05: rom_data = 8'h20;
      5'h06: rom_data = 8'h03;
      5'h07: rom_data = 8'h20;
      5'h08: rom_data = 8'h02;
      5'h09: rom_data = 8'h21;
      5'h0A: rom_data = 8'hFF;
      5'h1E: rom_data = 8'h03;
      5'h1F: rom_data = 8'h04;
      default: rom_data = 8'h00;
    endcase
  end

  assign bus.rom_dout = (rom_cs && bus.mem_read) ? rom_data : 8'h00;
  assign ram_dout     = ram[bus.adrs[1:0]];
  assign bus.mem2cpu  = ram_cs ? ram_dout : bus.rom_dout;

  // Stores outside the RAM window fall on the floor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram <= '{default: 8'h00};
    end else if (ram_cs && bus.mem_write) begin
      ram[bus.adrs[1:0]] <= bus.dout;
    end
  end

  assign ram20 = ram[0];
  assign ram21 = ram[1];
  assign ram22 = ram[2];
  assign ram23 = ram[3];

  // ---------------- control decode ----------------
  always_comb begin
    a_sel        = 1'b0;
    alu_sel      = ALU_A;
    pr_load      = 1'b0;
    mar_load     = 1'b0;
    mar_from_din = 1'b0;
    ir_load      = 1'b0;
    gr_load      = 1'b0;
    sc_clear     = 1'b0;
    sc_hold      = 1'b0;
    case (step)
      SC0: mar_load = 1'b1;
      SC1: begin
        ir_load = 1'b1;
        alu_sel = ALU_INC;
        pr_load = 1'b1;
      end
      SC2: begin
        if (ir == OP_HLT) sc_hold  = 1'b1;
        else              mar_load = 1'b1;
      end
      SC3: begin
        pr_load = 1'b1;
        if (ir == OP_JMP) begin
          alu_sel  = ALU_B;
          sc_clear = 1'b1;
        end else begin
          alu_sel      = ALU_INC;
          mar_load     = 1'b1;
          mar_from_din = 1'b1;
        end
      end
      SC4: begin
        sc_clear = 1'b1;
        if (ir == OP_LD) begin
          alu_sel = ALU_B;
          gr_load = 1'b1;
        end else if (ir == OP_ADD) begin
          a_sel   = 1'b1;
          alu_sel = ALU_ADD;
          gr_load = 1'b1;
        end
      end
      default: sc_clear = 1'b1;
    endcase
  end

  assign alu_a = a_sel ? gr : pr;

  always_comb begin
    alu_y = alu_a;
    case (alu_sel)
      ALU_A:   alu_y = alu_a;
      ALU_INC: alu_y = alu_a + 8'd1;
      ALU_ADD: alu_y = alu_a + bus.mem2cpu;
      ALU_B:   alu_y = bus.mem2cpu;
      default: alu_y = alu_a;
    endcase
  end

  always_comb begin
    if (sc_clear)     step_nxt = SC0;
    else if (sc_hold) step_nxt = step;
    else              step_nxt = step_t'(step + 3'd1);
  end

  // Strobes are registered from the next step so they cover the whole access cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step          <= SC0;
      pr            <= 8'h00;
      mar           <= 8'h00;
      ir            <= 8'h00;
      gr            <= 8'h00;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
    end else begin
      step <= step_nxt;
      if (pr_load)  pr  <= alu_y;
      if (mar_load) mar <= mar_from_din ? bus.mem2cpu : alu_y;
      if (ir_load)  ir  <= bus.mem2cpu;
      if (gr_load)  gr  <= alu_y;
      bus.mem_read  <= (step_nxt == SC1) || (step_nxt == SC3) ||
                       ((step_nxt == SC4) && ((ir == OP_LD) || (ir == OP_ADD)));
      bus.mem_write <= (step_nxt == SC4) && (ir == OP_ST);
    end
  end

  assign sc = step;

endmodule

// File: tb/tb_cpu_system.sv
// Bench for cpu_system: instruction-effect model checked every cycle, plus pinned
// program results, mid-cycle reset, HLT behaviour and memory-map reads.
module tb_cpu_system;

  logic       clk;
  logic       rst;
  logic [7:0] pr, mar, ir, gr;
  logic [2:0] sc;
  logic [7:0] ram20, ram21, ram22, ram23;

  cpu_bus_if bus ();

  cpu_system dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .pr    (pr),
    .mar   (mar),
    .ir    (ir),
    .gr    (gr),
    .sc    (sc),
    .ram20 (ram20),
    .ram21 (ram21),
    .ram22 (ram22),
    .ram23 (ram23)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int first_wr = 0;
  int n_wr  = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [7:0] OP_LD  = 8'h01;
  localparam logic [7:0] OP_ST  = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_JMP = 8'h04;
  localparam logic [7:0] OP_HLT = 8'hFF;

  logic [7:0] m_rom [32];
  logic [7:0] m_ram [4];
  logic [7:0] m_pr, m_gr, m_ir, m_mar, m_opnd;
  int         m_pos;
  logic       m_halt;

  initial begin
    for (int i = 0; i < 32; i++) m_rom[i] = 8'h00;
    m_rom[0]  = 8'h01; m_rom[1]  = 8'h1E;
    m_rom[2]  = 8'h03; m_rom[3]  = 8'h1F;
    m_rom[4]  = 8'h02; m_rom[5]  = 8'h20;
    m_rom[6]  = 8'h03; m_rom[7]  = 8'h20;
    m_rom[8]  = 8'h02; m_rom[9]  = 8'h21;
    m_rom[10] = 8'hFF;
    m_rom[30] = 8'h03; m_rom[31] = 8'h04;
  end

  function automatic logic [7:0] mem_rd(input logic [7:0] a);
    if (a < 8'h20)       return m_rom[a[4:0]];
    else if (a <= 8'h23) return m_ram[a[1:0]];
    else                 return 8'h00;
  endfunction

  task automatic model_reset();
    m_pr = 8'h00; m_gr = 8'h00; m_ir = 8'h00; m_mar = 8'h00; m_opnd = 8'h00;
    m_pos = 0; m_halt = 1'b0;
    for (int i = 0; i < 4; i++) m_ram[i] = 8'h00;
  endtask

  // One clock of progress through the current instruction: the opcode byte lands
  // after the 2nd cycle, the operand after the 4th, the effect after the 5th.
  task automatic model_cycle();
    if (m_halt) return;
    m_pos++;
    case (m_pos)
      1: m_mar = m_pr;
      2: begin
        m_ir = mem_rd(m_pr);
        m_pr = m_pr + 8'd1;
        if (m_ir == OP_HLT) m_halt = 1'b1;
      end
      3: m_mar = m_pr;
      4: begin
        m_opnd = mem_rd(m_pr);
        if (m_ir == OP_JMP) begin
          m_pr  = m_opnd;
          m_pos = 0;
        end else begin
          m_pr  = m_pr + 8'd1;
          m_mar = m_opnd;
        end
      end
      default: begin
        if (m_ir == OP_LD)       m_gr = mem_rd(m_mar);
        else if (m_ir == OP_ADD) m_gr = m_gr + mem_rd(m_mar);
        else if (m_ir == OP_ST && m_mar >= 8'h20 && m_mar <= 8'h23) m_ram[m_mar[1:0]] = m_gr;
        m_pos = 0;
      end
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
      cyc <= 0;
    end else begin
      model_cycle();
      cyc <= cyc + 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      chk("sc",    {5'b0, sc}, 8'(m_pos));
      chk("pr",    pr,    m_pr);
      chk("ir",    ir,    m_ir);
      chk("gr",    gr,    m_gr);
      chk("mar",   mar,   m_mar);
      chk("ram20", ram20, m_ram[0]);
      chk("ram21", ram21, m_ram[1]);
      chk("ram22", ram22, m_ram[2]);
      chk("ram23", ram23, m_ram[3]);
      chk("mem_write", {7'b0, bus.mem_write},
          {7'b0, (m_pos == 4) && (m_ir == OP_ST)});
      chk("mem_read", {7'b0, bus.mem_read},
          {7'b0, (m_pos == 1) || (m_pos == 3) ||
                 ((m_pos == 4) && ((m_ir == OP_LD) || (m_ir == OP_ADD)))});
      if (bus.adrs >= 8'h20 && bus.adrs <= 8'h23) begin
        chk("rom_dout_in_ram", bus.rom_dout, 8'h00);
        chk("mem2cpu_ram", bus.mem2cpu, m_ram[bus.adrs[1:0]]);
      end
      if (bus.mem_write) begin
        if (first_wr == 0) first_wr = cyc + 1;
        n_wr++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic at_cycle(input int k);
    int guard;
    guard = 0;
    while (cyc != k) begin
      @(negedge clk);
      guard++;
      if (guard > 500) begin
        n_cmp++;
        n_err++;
        $display("FAIL at_cycle_timeout: got cycle %0d expected %0d", cyc, k);
        return;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_pr"},  pr,  8'h00);
    chk({tag, "_mar"}, mar, 8'h00);
    chk({tag, "_ir"},  ir,  8'h00);
    chk({tag, "_gr"},  gr,  8'h00);
    chk({tag, "_sc"},  {5'b0, sc}, 8'h00);
    chk({tag, "_ram20"}, ram20, 8'h00);
    chk({tag, "_ram21"}, ram21, 8'h00);
    chk({tag, "_ram22"}, ram22, 8'h00);
    chk({tag, "_ram23"}, ram23, 8'h00);
    chk({tag, "_rd"}, {7'b0, bus.mem_read},  8'h00);
    chk({tag, "_wr"}, {7'b0, bus.mem_write}, 8'h00);
  endtask

  task automatic check_program(input string tag);
    at_cycle(5);
    chk({tag, "_c5_ir"}, ir, 8'h01);
    chk({tag, "_c5_gr"}, gr, 8'h03);
    chk({tag, "_c5_pr"}, pr, 8'h02);
    chk({tag, "_c5_sc"}, {5'b0, sc}, 8'h00);
    at_cycle(10);
    chk({tag, "_c10_gr"}, gr, 8'h07);
    at_cycle(15);
    chk({tag, "_c15_ram20"}, ram20, 8'h07);
    chk({tag, "_c15_first_wr"}, 8'(first_wr), 8'd15);
    chk({tag, "_c15_n_wr"}, 8'(n_wr), 8'd1);
    chk({tag, "_c15_mem2cpu"}, bus.mem2cpu, 8'h07);
    chk({tag, "_c15_rom_dout"}, bus.rom_dout, 8'h00);
    at_cycle(25);
    chk({tag, "_c25_gr"}, gr, 8'h0E);
    chk({tag, "_c25_ram21"}, ram21, 8'h0E);
    chk({tag, "_c25_ram22"}, ram22, 8'h00);
    chk({tag, "_c25_ram23"}, ram23, 8'h00);
    at_cycle(30);
    chk({tag, "_hlt_sc"}, {5'b0, sc}, 8'h02);
    chk({tag, "_hlt_pr"}, pr, 8'h0B);
    chk({tag, "_hlt_ir"}, ir, 8'hFF);
    chk({tag, "_hlt_gr"}, gr, 8'h0E);
    at_cycle(40);
    chk({tag, "_hlt_sc_hold"}, {5'b0, sc}, 8'h02);
    chk({tag, "_hlt_pr_hold"}, pr, 8'h0B);
    chk({tag, "_hlt_n_wr"}, 8'(n_wr), 8'd2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    #60;
    check_reset_state("por");
    #10 rst = 1'b1;

    check_program("run1");

    // Asynchronous reset in the middle of a HLT cycle, then a full re-run.
    #10 rst = 1'b0;
    #5;
    check_reset_state("async");
    first_wr = 0;
    n_wr     = 0;
    #20 rst = 1'b1;

    check_program("run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
